// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and derived widths for the memory line responder.
//   mem_state_t : responder FSM state (2-bit encoding)
//   BEAT_W      : beat-index width for the default line size
//   MEM_IDX_W   : backing-array index width for the default depth
// Modules with non-default parameters derive their own widths locally from
// their parameters; these constants describe the standard build.
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATENCY = 2'd1,
        BEAT    = 2'd2,
        DONE    = 2'd3
    } mem_state_t;

    localparam int DEF_WORDS_PER_LINE = 8;
    localparam int DEF_MEM_WORDS      = 4096;

    localparam int BEAT_W    = $clog2(DEF_WORDS_PER_LINE);
    localparam int MEM_IDX_W = $clog2(DEF_MEM_WORDS);

endpackage

// File: rtl/mem_array.sv
// ---------------------------------------------------------------------------
// mem_array
// Backing word store: synchronous write, asynchronous (combinational) read.
// Contents are deliberately not reset.
//   clk    : clock
//   we_i   : write enable, word captured at the rising edge
//   widx   : write word index
//   wdata  : write word
//   ridx   : read word index
//   rdata  : read word, follows ridx combinationally
// ---------------------------------------------------------------------------
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/mem_line_responder.sv
// ---------------------------------------------------------------------------
// mem_line_responder
// Memory-side responder for the cache miss/writeback handshake. Accepts one
// line request at a time, waits LAT cycles, streams WORDS_PER_LINE beats (one
// word per cycle) and then pulses rdy for one cycle.
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   req        : request strobe, only looked at in IDLE
//   we         : 1 = line writeback, 0 = line fill (sampled with req)
//   addr       : word address; the in-line offset bits are ignored
//   wdata      : write word for the current beat
//   rdata      : read word for the current fill beat, 0 otherwise
//   data_valid : high on each beat cycle
//   beat_idx   : index of the current beat word
//   busy       : high whenever a transaction is in flight
//   rdy        : one-cycle completion pulse
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for req; latches we and line address on acceptance
// LATENCY | access latency, lat_cnt counts down to terminal count 0
// BEAT    | one word per cycle, beat_cnt = beat index
// DONE    | single-cycle rdy pulse, returns to IDLE
// ---------------------------------------------------------------------------
module mem_line_responder
    import mem_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int WORDS_PER_LINE = 8,
    parameter int LAT            = 4,
    parameter int MEM_WORDS      = 4096
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req,
    input  logic                              we,
    input  logic [ADDR_W-1:0]                 addr,
    input  logic [DATA_W-1:0]                 wdata,
    output logic [DATA_W-1:0]                 rdata,
    output logic                              data_valid,
    output logic [$clog2(WORDS_PER_LINE)-1:0] beat_idx,
    output logic                              busy,
    output logic                              rdy
);

    localparam int LINE_BEAT_W = $clog2(WORDS_PER_LINE);
    localparam int LINE_IDX_W  = $clog2(MEM_WORDS);
    localparam int LINE_W      = ADDR_W - LINE_BEAT_W;

    // Counter is loaded with LAT-1 so LATENCY lasts exactly LAT cycles.
    localparam logic [3:0]             LAT_INIT  = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
    localparam logic [LINE_BEAT_W-1:0] LAST_BEAT = LINE_BEAT_W'(WORDS_PER_LINE - 1);

    mem_state_t              state, state_nxt;
    logic [3:0]              lat_cnt, lat_cnt_nxt;
    logic [LINE_BEAT_W-1:0]  beat_cnt, beat_cnt_nxt;
    logic                    we_q, we_q_nxt;
    logic [LINE_W-1:0]       line_q, line_q_nxt;

    logic [LINE_IDX_W-1:0]   mem_idx;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    mem_we;

    // Offset bits of addr are intentionally ignored: requests are line-aligned.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^addr[LINE_BEAT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat_cnt  <= 4'd0;
            beat_cnt <= '0;
            we_q     <= 1'b0;
            line_q   <= '0;
        end else begin
            state    <= state_nxt;
            lat_cnt  <= lat_cnt_nxt;
            beat_cnt <= beat_cnt_nxt;
            we_q     <= we_q_nxt;
            line_q   <= line_q_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lat_cnt_nxt  = lat_cnt;
        beat_cnt_nxt = beat_cnt;
        we_q_nxt     = we_q;
        line_q_nxt   = line_q;

        case (state)
            IDLE: begin
                beat_cnt_nxt = '0;
                if (req) begin
                    we_q_nxt   = we;
                    line_q_nxt = addr[ADDR_W-1:LINE_BEAT_W];
                    if (LAT == 0) begin
                        state_nxt = BEAT;
                    end else begin
                        state_nxt   = LATENCY;
                        lat_cnt_nxt = LAT_INIT;
                    end
                end
            end
            LATENCY: begin
                if (lat_cnt == 4'd0) begin
                    state_nxt = BEAT;
                end else begin
                    lat_cnt_nxt = lat_cnt - 4'd1;
                end
            end
            BEAT: begin
                // Counter wraps back to 0 on the last beat; the compare ends it.
                beat_cnt_nxt = beat_cnt + LINE_BEAT_W'(1);
                if (beat_cnt == LAST_BEAT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Line addresses beyond the array depth alias silently.
    assign mem_idx = LINE_IDX_W'({line_q, beat_cnt});
    assign mem_we  = (state == BEAT) && we_q;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_WORDS),
        .IDX_W  (LINE_IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .we_i  (mem_we),
        .widx  (mem_idx),
        .wdata (wdata),
        .ridx  (mem_idx),
        .rdata (mem_rdata)
    );

    assign data_valid = (state == BEAT);
    assign beat_idx   = beat_cnt;
    assign busy       = (state != IDLE);
    assign rdy        = (state == DONE);
    assign rdata      = (data_valid && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_line_responder.sv
module tb_mem_line_responder;

    logic clk;
    logic rst_n;

    // Index 0: LAT=4 build, index 1: LAT=0 build.
    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0][15:0] addr;
    logic [1:0][15:0] wdata;

    logic [15:0] rdata_a, rdata_b;
    logic        dv_a, dv_b, busy_a, busy_b, rdy_a, rdy_b;
    logic [2:0]  bidx_a, bidx_b;

    logic [1:0][15:0] rdata_v;
    logic [1:0]       dv_v, busy_v, rdy_v;
    logic [1:0][2:0]  bidx_v;

    assign rdata_v = {rdata_b, rdata_a};
    assign dv_v    = {dv_b, dv_a};
    assign busy_v  = {busy_b, busy_a};
    assign rdy_v   = {rdy_b, rdy_a};
    assign bidx_v  = {bidx_b, bidx_a};

    mem_line_responder #(
        .DATA_W(16), .ADDR_W(16), .WORDS_PER_LINE(8), .LAT(4), .MEM_WORDS(4096)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata_a), .data_valid(dv_a), .beat_idx(bidx_a),
        .busy(busy_a), .rdy(rdy_a)
    );

    mem_line_responder #(
        .DATA_W(16), .ADDR_W(16), .WORDS_PER_LINE(8), .LAT(0), .MEM_WORDS(4096)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata_b), .data_valid(dv_b), .beat_idx(bidx_b),
        .busy(busy_b), .rdy(rdy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mn[d] = cycles elapsed since acceptance (0 = idle). A transaction is
    // LAT cycles of wait, 8 beats, one rdy cycle: total LAT+9 busy cycles.
    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : 0;
    endfunction

    function automatic int mkey(input int d, input int line, input int k);
        return d * 4096 + ((line * 8 + k) % 4096);
    endfunction

    int          mn   [2];
    bit          mwe  [2];
    int          mline[2];
    logic [15:0] mmem [int];
    int          acc_q[$];
    int          cyc = 0;
    int          rdy_cnt0 = 0;

    always @(posedge clk) begin
        int lm;
        int k;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            lm = lat_of(d);
            if (!rst_n) begin
                mn[d] = 0;
            end else if (mn[d] == 0) begin
                if (req[d]) begin
                    mn[d]    = 1;
                    mwe[d]   = we[d];
                    mline[d] = int'(addr[d]) / 8;
                    if (d == 0) acc_q.push_back(cyc);
                end
            end else begin
                if (mn[d] >= lm + 1 && mn[d] <= lm + 8 && mwe[d]) begin
                    k = mn[d] - lm - 1;
                    mmem[mkey(d, mline[d], k)] = wdata[d];
                end
                mn[d] = (mn[d] == lm + 9) ? 0 : mn[d] + 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int lm;
        bit e_dv;
        int k;
        int key;
        for (int d = 0; d < 2; d++) begin
            lm = lat_of(d);
            if (!rst_n) begin
                chk($sformatf("rst_busy%0d", d), busy_v[d], 0);
                chk($sformatf("rst_dv%0d", d), dv_v[d], 0);
                chk($sformatf("rst_rdy%0d", d), rdy_v[d], 0);
                chk($sformatf("rst_bidx%0d", d), bidx_v[d], 0);
                chk($sformatf("rst_rdata%0d", d), rdata_v[d], 0);
            end else begin
                e_dv = (mn[d] >= lm + 1) && (mn[d] <= lm + 8);
                k    = e_dv ? mn[d] - lm - 1 : 0;
                chk($sformatf("busy%0d", d), busy_v[d], mn[d] != 0);
                chk($sformatf("data_valid%0d", d), dv_v[d], e_dv);
                chk($sformatf("rdy%0d", d), rdy_v[d], mn[d] == lm + 9);
                chk($sformatf("beat_idx%0d", d), bidx_v[d], k);
                if (!e_dv) begin
                    chk($sformatf("rdata_idle%0d", d), rdata_v[d], 0);
                end else if (!mwe[d]) begin
                    key = mkey(d, mline[d], k);
                    if (mmem.exists(key)) chk($sformatf("rdata%0d", d), rdata_v[d], mmem[key]);
                end
            end
        end
        if (rst_n && rdy_a) rdy_cnt0++;
    end

    // ---------------- directed stimulus ----------------
    logic [15:0] got [8];

    // One transaction on DUT d. first_c / rdy_c are the hand-computed cycle
    // numbers (counted from the acceptance edge) of beat 0 and of rdy.
    task automatic run_txn(input int d, input bit w, input logic [15:0] a,
                           input logic [15:0] base, input int first_c, input int rdy_c,
                           input bit inject);
        @(posedge clk); #1;
        req[d] = 1'b1; we[d] = w; addr[d] = a;
        @(posedge clk); #1;
        req[d] = 1'b0; we[d] = ~w; addr[d] = 16'hFFFF;
        for (int c = 1; c <= rdy_c; c++) begin
            if (c >= first_c && c < first_c + 8) wdata[d] = base + 16'(c - first_c);
            else wdata[d] = 16'hDEAD;
            if (inject && c == 2) begin
                req[d] = 1'b1; we[d] = 1'b1; addr[d] = 16'h0200;
            end
            if (inject && c == 3) req[d] = 1'b0;
            @(negedge clk);
            chk("dv_window", dv_v[d], (c >= first_c) && (c < first_c + 8));
            chk("rdy_cycle", rdy_v[d], c == rdy_c);
            if (c >= first_c && c < first_c + 8) got[c - first_c] = rdata_v[d];
            @(posedge clk); #1;
        end
        chk("idle_after_rdy", busy_v[d], 0);
    endtask

    initial begin
        int r0;
        bit pb;
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        #2;
        chk("reset_busy_a", busy_a, 0);
        chk("reset_dv_a", dv_a, 0);
        chk("reset_rdy_a", rdy_a, 0);
        chk("reset_bidx_a", bidx_a, 0);
        chk("reset_rdata_a", rdata_a, 0);
        chk("reset_busy_b", busy_b, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read with offset bits set.
        run_txn(0, 1'b1, 16'h0010, 16'hA000, 5, 13, 1'b0);
        run_txn(0, 1'b0, 16'h0013, 16'h0000, 5, 13, 1'b0);
        for (int k = 0; k < 8; k++) chk("rd_line_0x0010", got[k], 32'hA000 + k);

        // Alias: line 0xF008 maps to array words 0x008..0x00F.
        run_txn(0, 1'b1, 16'hF008, 16'h5A5A, 5, 13, 1'b0);
        run_txn(0, 1'b0, 16'h0008, 16'h0000, 5, 13, 1'b0);
        for (int k = 0; k < 8; k++) chk("wrap_0x0008", got[k], 32'h5A5A + k);

        // Dropped request during LATENCY.
        run_txn(0, 1'b1, 16'h0200, 16'h1230, 5, 13, 1'b0);
        r0 = rdy_cnt0;
        run_txn(0, 1'b0, 16'h0100, 16'h0000, 5, 13, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        chk("dropped_rdy_count", rdy_cnt0 - r0, 1);
        run_txn(0, 1'b0, 16'h0200, 16'h0000, 5, 13, 1'b0);
        for (int k = 0; k < 8; k++) chk("line_0x0200_kept", got[k], 32'h1230 + k);

        // Reset in the middle of a read burst.
        run_txn(0, 1'b1, 16'h0040, 16'h4000, 5, 13, 1'b0);
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0040;
        @(posedge clk); #1;
        req[0] = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        r0 = rdy_cnt0;
        rst_n = 1'b0;
        #1;
        chk("midrst_dv", dv_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_rdy", rdy_a, 0);
        chk("midrst_bidx", bidx_a, 0);
        chk("midrst_rdata", rdata_a, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        chk("midrst_no_rdy", rdy_cnt0 - r0, 0);
        run_txn(0, 1'b0, 16'h0040, 16'h0000, 5, 13, 1'b0);
        for (int k = 0; k < 8; k++) chk("after_rst_0x0040", got[k], 32'h4000 + k);

        // Back-to-back with req held high and we alternating per transaction.
        acc_q.delete();
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0010;
        pb = 1'b0;
        for (int i = 0; i < 62; i++) begin
            @(negedge clk);
            if (busy_a && !pb) we[0] = ~we[0];
            pb = busy_a;
            wdata[0] = 16'(i * 37 + 5);
        end
        req[0] = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("b2b_count", acc_q.size(), 5);
        for (int i = 0; i + 1 < acc_q.size(); i++)
            chk("b2b_spacing", acc_q[i + 1] - acc_q[i], 14);

        // LAT=0 build: beats in T0+1..T0+8, rdy T0+9, idle T0+10.
        run_txn(1, 1'b1, 16'h0030, 16'hB000, 1, 9, 1'b0);
        run_txn(1, 1'b0, 16'h0035, 16'h0000, 1, 9, 1'b0);
        for (int k = 0; k < 8; k++) chk("lat0_rd_0x0030", got[k], 32'hB000 + k);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
